condlogic: RTL and testbench

- Conditional-execution and flag-state unit for the multicycle ARM datapath, directly downstream of the ALU.
- Captures the ALU's NZCV flags into architectural flag registers under FlagW control.
- Evaluates the 4-bit ARM condition field against the stored flags.
- Gates the controller's write strobes (PCWrite, RegWrite, MemWrite) and the flag writes by the condition result.

---
 rtl/condlogic_pkg.sv | 38 +++
 rtl/condlogic_if.sv | 28 ++
 rtl/condlogic_condcheck.sv | 41 ++++
 rtl/condlogic.sv | 57 +++++
 tb/tb_condlogic.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/condlogic_pkg.sv
// Shared definitions for the ARM conditional-execution unit: condition codes,
// NZCV bit positions and FlagW field encodings.
package condlogic_pkg;

  typedef enum logic [3:0] {
    COND_EQ  = 4'h0,
    COND_NE  = 4'h1,
    COND_CS  = 4'h2,
    COND_CC  = 4'h3,
    COND_MI  = 4'h4,
    COND_PL  = 4'h5,
    COND_VS  = 4'h6,
    COND_VC  = 4'h7,
    COND_HI  = 4'h8,
    COND_LS  = 4'h9,
    COND_GE  = 4'hA,
    COND_LT  = 4'hB,
    COND_GT  = 4'hC,
    COND_LE  = 4'hD,
    COND_AL  = 4'hE,
    COND_UND = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] FLAGW_NZ  = 2'b10;
  localparam logic [1:0] FLAGW_ALL = 2'b11;
  localparam logic [1:0] FLAGW_CV  = FLAGW_ALL ^ FLAGW_NZ;

  // Signed "greater or equal" after a compare: N and V agree.
  function automatic logic signed_ge(input logic [3:0] flags);
    return flags[FLAG_N] == flags[FLAG_V];
  endfunction

endpackage

// File: rtl/condlogic_if.sv
// Controller-side bundle of the conditional-execution unit: decoder/FSM
// requests and ALU flags in, gated strobes and architectural flags out.
interface condlogic_if;

  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondEx;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    input  PCWrite, RegWrite, MemWrite, Flags, CondEx
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    output PCWrite, RegWrite, MemWrite, Flags, CondEx
  );

endinterface

// File: rtl/condlogic_condcheck.sv
// Purely combinational ARM condition evaluator: Cond x {N,Z,C,V} -> pass.
// Shared with the pipelined core, so it holds no state.
module condcheck
  import condlogic_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves the
    // output unassigned, which would infer a latch.
    cond_ex_o = 1'b1;
    case (cond_e'(cond_i))
      COND_EQ:           cond_ex_o = z;
      COND_NE:           cond_ex_o = ~z;
      COND_CS:           cond_ex_o = c;
      COND_CC:           cond_ex_o = ~c;
      COND_MI:           cond_ex_o = n;
      COND_PL:           cond_ex_o = ~n;
      COND_VS:           cond_ex_o = v;
      COND_VC:           cond_ex_o = ~v;
      COND_HI:           cond_ex_o = c & ~z;
      COND_LS:           cond_ex_o = ~c | z;
      COND_GE:           cond_ex_o = signed_ge(flags_i);
      COND_LT:           cond_ex_o = ~signed_ge(flags_i);
      COND_GT:           cond_ex_o = ~z & signed_ge(flags_i);
      COND_LE:           cond_ex_o = z | ~signed_ge(flags_i);
      COND_AL, COND_UND: cond_ex_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/condlogic.sv
// Conditional-execution and flag-state unit of the multicycle ARM datapath:
// holds NZCV, evaluates Cond against it and gates the controller's write strobes.
module condlogic
  import condlogic_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic          clk,
  input  logic          reset,
  condlogic_if.slave    bus
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       cond_ex_comb;
  logic [1:0] flag_write;

  // Evaluated on the stored flags, so a flag update in this cycle only
  // affects the next instruction.
  condcheck u_condcheck (
    .cond_i    (bus.Cond),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex_comb)
  );

  assign flag_write = bus.FlagW & {2{cond_ex_comb}};
  assign cond_ex_d  = cond_ex_comb;

  always_comb begin
    flags_d = flags_q;
    if ((flag_write & FLAGW_NZ) != 2'b00)
      flags_d[FLAG_N:FLAG_Z] = bus.ALUFlags[FLAG_N:FLAG_Z];
    if ((flag_write & FLAGW_CV) != 2'b00)
      flags_d[FLAG_C:FLAG_V] = bus.ALUFlags[FLAG_C:FLAG_V];
  end

  // NOTE: non-blocking assignments for all state so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= RESET_FLAGS;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  // Strobes depend only on registered state plus FSM requests; ALUFlags
  // reaches the outputs solely through flags_q.
  assign bus.RegWrite = bus.RegW & cond_ex_q;
  assign bus.MemWrite = bus.MemW & cond_ex_q;
  assign bus.PCWrite  = (bus.PCS & cond_ex_q) | bus.NextPC;
  assign bus.Flags    = flags_q;
  assign bus.CondEx   = cond_ex_q;

endmodule

// File: tb/tb_condlogic.sv
// Scoreboard bench for condlogic: directed plan sequences followed by random
// traffic, checked every cycle against an instruction-level NZCV model.
module tb_condlogic;

  localparam logic [3:0] RST_FLAGS = 4'b0000;

  typedef struct packed {
    logic       rst;
    logic [3:0] cond;
    logic [3:0] aluf;
    logic [1:0] fw;
    logic       pcs;
    logic       npc;
    logic       regw;
    logic       memw;
  } stim_t;

  typedef struct {
    logic [3:0] flags;
    logic       condex;
    logic       pcw;
    logic       rw;
    logic       mw;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic reset;
  condlogic_if bus ();

  condlogic #(.RESET_FLAGS(RST_FLAGS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  exp_t  exp_q[$];
  event  probe_ev;
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model: architectural flags and the latched condition result.
  logic [3:0] m_flags;
  logic       m_condex;
  stim_t      cur;

  // Each odd code is the complement of the even code before it; 0xE/0xF pass.
  function automatic logic holds(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return base ^ cond[0];
  endfunction

  task automatic model_edge();
    logic pass;
    if (cur.rst) begin
      m_flags  = RST_FLAGS;
      m_condex = 1'b0;
    end else begin
      pass = holds(cur.cond, m_flags);
      if (pass && cur.fw[1]) m_flags[3:2] = cur.aluf[3:2];
      if (pass && cur.fw[0]) m_flags[1:0] = cur.aluf[1:0];
      m_condex = pass;
    end
  endtask

  task automatic apply_and_expect(input stim_t s, input string tag);
    exp_t e;
    cur           = s;
    reset         = s.rst;
    bus.Cond      = s.cond;
    bus.ALUFlags  = s.aluf;
    bus.FlagW     = s.fw;
    bus.PCS       = s.pcs;
    bus.NextPC    = s.npc;
    bus.RegW      = s.regw;
    bus.MemW      = s.memw;
    if (s.rst) begin
      m_flags  = RST_FLAGS;
      m_condex = 1'b0;
    end
    e.flags  = m_flags;
    e.condex = m_condex;
    e.rw     = s.regw & m_condex;
    e.mw     = s.memw & m_condex;
    e.pcw    = (s.pcs & m_condex) | s.npc;
    e.tag    = tag;
    exp_q.push_back(e);
  endtask

  // One instruction cycle: clock edge, then new inputs, then expectation.
  task automatic drive(input stim_t s, input string tag);
    @(posedge clk);
    model_edge();
    #1;
    apply_and_expect(s, tag);
  endtask

  function automatic stim_t st(input logic [3:0] cond, input logic [3:0] aluf = 4'h0,
                               input logic [1:0] fw = 2'b00, input logic pcs = 1'b0,
                               input logic regw = 1'b0, input logic rst = 1'b0);
    stim_t s;
    s.rst = rst; s.cond = cond; s.aluf = aluf; s.fw = fw;
    s.pcs = pcs; s.npc = 1'b0; s.regw = regw; s.memw = regw;
    return s;
  endfunction

  task automatic set_flags(input logic [3:0] f);
    drive(st(4'hE, f, 2'b11), "set_flags");
  endtask

  // Monitor: compares whenever the DUT outputs are sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or probe_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.Flags !== e.flags || bus.CondEx !== e.condex || bus.PCWrite !== e.pcw ||
            bus.RegWrite !== e.rw || bus.MemWrite !== e.mw) begin
          n_bad++;
          $display("FAIL %s: got Flags=%b CondEx=%b PCWrite=%b RegWrite=%b MemWrite=%b, want Flags=%b CondEx=%b PCWrite=%b RegWrite=%b MemWrite=%b",
                   e.tag, bus.Flags, bus.CondEx, bus.PCWrite, bus.RegWrite, bus.MemWrite,
                   e.flags, e.condex, e.pcw, e.rw, e.mw);
        end
      end
    end
  end

  initial begin
    stim_t s;
    // Reset with the clock stopped.
    s = st(4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    #2;
    apply_and_expect(s, "reset_idle");
    ->probe_ev;
    #2;
    s.npc = 1'b1;
    apply_and_expect(s, "reset_nextpc");
    ->probe_ev;
    #2;
    clk_run = 1'b1;

    drive(st(4'hE), "release");
    // SUBS equal, then EQ / NE gated register writes.
    drive(st(4'hE, 4'b0110, 2'b11), "subs");
    drive(st(4'h0, 4'h0, 2'b00, 1'b0, 1'b1), "eq_issue");
    drive(st(4'h1, 4'h0, 2'b00, 1'b0, 1'b1), "eq_regw");
    drive(st(4'hE), "ne_regw");
    // Partial NZ write preserves C,V.
    set_flags(4'b0011);
    drive(st(4'hE, 4'b1000, 2'b10), "partial");
    drive(st(4'hE), "partial_chk");
    // Failing condition suppresses the flag write.
    set_flags(4'b0000);
    drive(st(4'h0, 4'b1111, 2'b11), "suppress");
    drive(st(4'hE), "suppress_chk");
    // Signed and unsigned compares.
    set_flags(4'b1001);
    drive(st(4'hA), "ge_1001");
    drive(st(4'hB), "lt_1001");
    drive(st(4'hC), "gt_1001");
    drive(st(4'hE), "gt_1001_res");
    set_flags(4'b1000);
    drive(st(4'hA), "ge_1000");
    drive(st(4'hD), "le_1000");
    drive(st(4'hE), "le_1000_res");
    set_flags(4'b0110);
    drive(st(4'h8), "hi_0110");
    drive(st(4'h9), "ls_0110");
    drive(st(4'hE), "ls_0110_res");
    // Branch on LT.
    set_flags(4'b1000);
    drive(st(4'hB, 4'h0, 2'b00, 1'b1), "branch_issue");
    drive(st(4'hB, 4'h0, 2'b00, 1'b1), "branch_lt");
    // Mid-instruction reset discards the pending write.
    set_flags(4'b1011);
    drive(st(4'hE), "pre_reset");
    drive(st(4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1), "mid_reset");
    drive(st(4'hE, 4'h0, 2'b00, 1'b0, 1'b1), "post_reset_regw");
    drive(st(4'hE, 4'h0, 2'b00, 1'b0, 1'b1), "post_reset_regw2");

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      s.rst  = ($urandom_range(0, 39) == 0);
      s.cond = 4'($urandom);
      s.aluf = 4'($urandom);
      s.fw   = 2'($urandom);
      s.pcs  = 1'($urandom);
      s.npc  = 1'($urandom);
      s.regw = 1'($urandom);
      s.memw = 1'($urandom);
      drive(s, "random");
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
